hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage 64-bit pipelined processor.

---
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and memory-busy freezes.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_ifid_rs1,
  input  logic [4:0]  i_ifid_rs2,
  input  logic        i_ifid_uses_rs2,
  input  logic        i_idex_mem_read,
  input  logic [4:0]  i_idex_rd,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_busy,
  output logic        o_pc_write,
  output logic        o_pc_sel,
  output logic        o_ifid_write,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_t;

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [CNT_W-1:0]   w_cnt_dec;
  logic               w_lu_hz;

  assign w_lu_hz = i_idex_mem_read && (i_idex_rd != 5'd0) &&
                   ((i_idex_rd == i_ifid_rs1) ||
                    (i_ifid_uses_rs2 && (i_idex_rd == i_ifid_rs2)));

  assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;

  // Priority is memory freeze, then taken branch, then the current state's own work.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    o_pc_write    = 1'b0;
    o_pc_sel      = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (!i_rst_n) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      w_next_state  = RUN;
      w_next_cnt    = '0;
    end else if (i_mem_busy) begin
      w_next_state = r_state;
    end else if (i_ex_branch_taken) begin
      o_pc_write    = 1'b1;
      o_pc_sel      = 1'b1;
      o_ifid_write  = 1'b1;
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_next_state = BR_FLUSH;
        w_next_cnt   = FL_RELOAD;
      end else begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_lu_hz) begin
            o_idex_bubble = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              w_next_state = LU_STALL;
              w_next_cnt   = LU_RELOAD;
            end
          end else begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
          end
        end
        LU_STALL: begin
          o_idex_bubble = 1'b1;
          w_next_cnt    = w_cnt_dec;
          if (r_cnt <= CNT_W'(1)) w_next_state = RUN;
        end
        BR_FLUSH: begin
          // IF/ID holds a squashed instruction here, so a load-use match is meaningless.
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
          o_ifid_flush = 1'b1;
          w_next_cnt   = w_cnt_dec;
          if (r_cnt <= CNT_W'(1)) w_next_state = RUN;
        end
        default: begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!o_pc_write && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (o_pc_sel && (r_flush_events != 32'hFFFF_FFFF))
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two configurations (LU=1/FL=1 and LU=3/FL=2)
// driven in lockstep and compared against a pending-cycles reference model.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rstN;
  logic [4:0] rs1, rs2, rd;
  logic       usesRs2, memRead, taken, busy;

  logic       pcWriteA, pcSelA, ifidWriteA, ifidFlushA, idexBubbleA;
  logic       pcWriteB, pcSelB, ifidWriteB, ifidFlushB, idexBubbleB;
  logic [4:0] vecA, vecB;

  int checks = 0;
  int errors = 0;

  int luCfg[2] = '{1, 3};
  int flCfg[2] = '{1, 2};
  int stallLeft[2];
  int flushLeft[2];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCntA, flushCntA, stallCntB, flushCntB;
  longint      expStall[2];
  longint      expFlush[2];
`endif

  hazard_stall_ctrl #(.LU_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4)) dutA (
    .i_clk(clk), .i_rst_n(rstN),
    .i_ifid_rs1(rs1), .i_ifid_rs2(rs2), .i_ifid_uses_rs2(usesRs2),
    .i_idex_mem_read(memRead), .i_idex_rd(rd),
    .i_ex_branch_taken(taken), .i_mem_busy(busy),
    .o_pc_write(pcWriteA), .o_pc_sel(pcSelA), .o_ifid_write(ifidWriteA),
    .o_ifid_flush(ifidFlushA), .o_idex_bubble(idexBubbleA)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(stallCntA), .o_flush_events(flushCntA)
`endif
  );

  hazard_stall_ctrl #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dutB (
    .i_clk(clk), .i_rst_n(rstN),
    .i_ifid_rs1(rs1), .i_ifid_rs2(rs2), .i_ifid_uses_rs2(usesRs2),
    .i_idex_mem_read(memRead), .i_idex_rd(rd),
    .i_ex_branch_taken(taken), .i_mem_busy(busy),
    .o_pc_write(pcWriteB), .o_pc_sel(pcSelB), .o_ifid_write(ifidWriteB),
    .o_ifid_flush(ifidFlushB), .o_idex_bubble(idexBubbleB)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(stallCntB), .o_flush_events(flushCntB)
`endif
  );

  assign vecA = {pcWriteA, pcSelA, ifidWriteA, ifidFlushA, idexBubbleA};
  assign vecB = {pcWriteB, pcSelB, ifidWriteB, ifidFlushB, idexBubbleB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one configuration's output vector {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble}.
  task automatic checkOutput(input int k, input logic [4:0] expected, input string tag);
    logic [4:0] observed;
    observed = (k == 0) ? vecA : vecB;
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s cfg%0d observed %b expected %b", tag, k, observed, expected);
    end
  endtask

  // Drives one cycle of inputs mid-period, checks both configurations, then advances the model.
  task automatic applyStimulus(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                               input logic u2, input logic mr, input logic [4:0] d,
                               input logic tk, input logic bz, input string tag);
    logic       hz;
    logic [4:0] exp;
    @(negedge clk);
    rstN = r; rs1 = s1; rs2 = s2; usesRs2 = u2;
    memRead = mr; rd = d; taken = tk; busy = bz;
    #1;
    hz = mr && (d != 5'd0) && ((d == s1) || (u2 && (d == s2)));
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        exp = 5'b00011;
        stallLeft[k] = 0;
        flushLeft[k] = 0;
      end else if (bz) begin
        exp = 5'b00000;
      end else if (tk) begin
        exp = 5'b11111;
        flushLeft[k] = flCfg[k] - 1;
        stallLeft[k] = 0;
      end else if (flushLeft[k] > 0) begin
        exp = 5'b10110;
        flushLeft[k]--;
      end else if (stallLeft[k] > 0) begin
        exp = 5'b00001;
        stallLeft[k]--;
      end else if (hz) begin
        exp = 5'b00001;
        stallLeft[k] = luCfg[k] - 1;
      end else begin
        exp = 5'b10100;
      end
      checkOutput(k, exp, tag);
`ifdef HAZARD_PERF_CNT_EN
      if (!r) begin
        expStall[k] = 0;
        expFlush[k] = 0;
      end else begin
        if (!exp[4] && expStall[k] < 64'hFFFF_FFFF) expStall[k]++;
        if (exp[3] && expFlush[k] < 64'hFFFF_FFFF) expFlush[k]++;
      end
`endif
    end
  endtask

  initial begin
    rstN = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    usesRs2 = 1'b0; memRead = 1'b0; taken = 1'b0; busy = 1'b0;
    stallLeft = '{0, 0};
    flushLeft = '{0, 0};
`ifdef HAZARD_PERF_CNT_EN
    expStall = '{0, 0};
    expFlush = '{0, 0};
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    applyStimulus(0, 5, 0, 0, 1, 5, 1, 0, "reset_ignores_inputs");
    applyStimulus(1, 1, 2, 1, 0, 3, 0, 0, "run_idle");

    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, "loaduse_t0");
    applyStimulus(1, 5, 0, 0, 0, 5, 0, 0, "loaduse_t1");
    applyStimulus(1, 5, 0, 0, 0, 5, 0, 0, "loaduse_t2");
    applyStimulus(1, 5, 0, 0, 0, 5, 0, 0, "loaduse_t3");

    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, "nohz_rd0");
    applyStimulus(1, 1, 7, 0, 1, 7, 0, 0, "nohz_rs2_unused");
    applyStimulus(1, 1, 7, 1, 1, 7, 0, 0, "hz_rs2_used");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "hz_rs2_tail1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "hz_rs2_tail2");

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "branch_t0");
    applyStimulus(1, 4, 0, 0, 1, 4, 0, 0, "branch_t1_hz_ignored");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "branch_t2");

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "branch_restart_t0");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "branch_restart_t1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "branch_restart_t2");

    applyStimulus(1, 9, 0, 0, 1, 9, 1, 1, "busy_all_events");
    applyStimulus(1, 9, 0, 0, 1, 9, 1, 1, "busy_hold");
    applyStimulus(1, 9, 0, 0, 1, 9, 1, 0, "busy_release_branch");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "busy_release_t1");

    applyStimulus(1, 6, 0, 0, 1, 6, 0, 0, "stall_abort_t0");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "stall_abort_branch");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "stall_abort_t2");

    applyStimulus(1, 8, 0, 0, 1, 8, 0, 0, "stall_busy_t0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, "stall_busy_freeze");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "stall_busy_t1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "stall_busy_t2");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "stall_busy_t3");

    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, "midreset_stall");
    applyStimulus(0, 5, 0, 0, 1, 5, 0, 0, "midreset_assert");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "midreset_release");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    "random");
    end

`ifdef HAZARD_PERF_CNT_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "perf_reset");
    applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, "perf_stall_t0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "perf_stall_t1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "perf_stall_t2");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "perf_branch");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "perf_idle1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "perf_idle2");
    @(posedge clk);
    #1;
    checks++;
    assert ({32'(expStall[1]), 32'(expFlush[1])} === {stallCntB, flushCntB}) else begin
      errors++;
      $error("[TB] FAIL perf_counts observed %0d/%0d expected %0d/%0d",
             stallCntB, flushCntB, expStall[1], expFlush[1]);
    end
    checks++;
    assert ({32'(expStall[0]), 32'(expFlush[0])} === {stallCntA, flushCntA}) else begin
      errors++;
      $error("[TB] FAIL perf_counts_a observed %0d/%0d expected %0d/%0d",
             stallCntA, flushCntA, expStall[0], expFlush[0]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
